// File: rtl/benes_pkg.sv
// rtl/benes_pkg.sv - shared types and helpers for the Benes control-word generator
package benes_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GEN  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  // Switch count of a WIDTH-port Benes network: (2*log2(W)-1) stages of W/2 switches.
  function automatic int nbits(input int width);
    return width * $clog2(width) - width / 2;
  endfunction

  function automatic int words(input int width);
    return (nbits(width) + 31) / 32;
  endfunction

  function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
    return (x << 13) ^ (x >> 17) ^ (x << 5);
  endfunction

endpackage

// File: rtl/benes_ctrl_gen_if.sv
// rtl/benes_ctrl_gen_if.sv - control/seed inputs and control-word stream of the generator
interface benes_ctrl_gen_if #(
  parameter int WIDTH = 8
);
  import benes_pkg::*;

  localparam int NBITS = nbits(WIDTH);

  logic             en;
  logic             seed_valid;
  logic [31:0]      seed_data;
  logic             ctrl_valid;
  logic             ctrl_ready;
  logic [NBITS-1:0] ctrl_data;
  logic             busy;

  modport master (
    input  en, seed_valid, seed_data, ctrl_ready,
    output ctrl_valid, ctrl_data, busy
  );

  modport slave (
    output en, seed_valid, seed_data, ctrl_ready,
    input  ctrl_valid, ctrl_data, busy
  );

endinterface

// File: rtl/xorshift32.sv
// rtl/xorshift32.sv - one combinational step of the 32-bit xorshift PRNG
module xorshift32
  import benes_pkg::*;
(
  input  logic [31:0] x_i,
  output logic [31:0] y_o
);

  assign y_o = xorshift32_step(x_i);

endmodule

// File: rtl/benes_ctrl_gen.sv
// rtl/benes_ctrl_gen.sv - fills a Benes switch-control word from a PRNG, one 32-bit word per cycle
module benes_ctrl_gen
  import benes_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter logic [31:0] SEED  = 32'h0000_0001
) (
  input logic              clk,
  input logic              rst,
  benes_ctrl_gen_if.master bus
);

  localparam int NBITS = nbits(WIDTH);
  localparam int WORDS = words(WIDTH);
  localparam int KW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e              fsm_q, fsm_d;
  logic [31:0]         prng_q, prng_d;
  logic [WORDS*32-1:0] acc_q, acc_d;
  logic [KW-1:0]       k_q, k_d;
  logic [NBITS-1:0]    ctrl_data_q, ctrl_data_d;
  logic                ctrl_valid_q, ctrl_valid_d;
  logic                busy_q, busy_d;

  logic [31:0] step_raw;
  logic [31:0] step_val;
  logic [31:0] seed_val;

  xorshift32 u_step (
    .x_i (prng_q),
    .y_o (step_raw)
  );

  // Zero is a fixed point of xorshift, so it is never allowed into the state.
  assign step_val = (step_raw == 32'h0) ? 32'h1 : step_raw;
  assign seed_val = (bus.seed_data == 32'h0) ? 32'h1 : bus.seed_data;

  always_comb begin
    fsm_d        = fsm_q;
    prng_d       = prng_q;
    acc_d        = acc_q;
    k_d          = k_q;
    ctrl_data_d  = ctrl_data_q;
    ctrl_valid_d = ctrl_valid_q;

    if (bus.seed_valid) begin
      prng_d       = seed_val;
      acc_d        = '0;
      k_d          = '0;
      ctrl_valid_d = 1'b0;
      fsm_d        = bus.en ? S_GEN : S_IDLE;
    end else begin
      unique case (fsm_q)
        S_IDLE: begin
          if (bus.en) fsm_d = S_GEN;
        end
        S_GEN: begin
          if (bus.en) begin
            prng_d = step_val;
            for (int w = 0; w < WORDS; w++) begin
              if (int'(k_q) == w) acc_d[w*32 +: 32] = step_val;
            end
            if (int'(k_q) == WORDS - 1) begin
              k_d          = '0;
              ctrl_data_d  = acc_d[NBITS-1:0];
              ctrl_valid_d = 1'b1;
              fsm_d        = S_HOLD;
            end else begin
              k_d = k_q + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (ctrl_valid_q && bus.ctrl_ready) begin
            ctrl_valid_d = 1'b0;
            fsm_d        = bus.en ? S_GEN : S_IDLE;
          end
        end
        default: fsm_d = S_IDLE;
      endcase
    end

    busy_d = (fsm_d == S_GEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= S_IDLE;
      prng_q       <= SEED;
      acc_q        <= '0;
      k_q          <= '0;
      ctrl_data_q  <= '0;
      ctrl_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      prng_q       <= prng_d;
      acc_q        <= acc_d;
      k_q          <= k_d;
      ctrl_data_q  <= ctrl_data_d;
      ctrl_valid_q <= ctrl_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.ctrl_data  = ctrl_data_q;
  assign bus.ctrl_valid = ctrl_valid_q;
  assign bus.busy       = busy_q;

endmodule

// File: doc/benes_ctrl_gen.md
BENES_CTRL_GEN -- requirements
Module: benes_ctrl_gen

Interface
REQ-001 Parameter WIDTH, default 8, is the Benes network port count; a power of two, at least 4.
REQ-002 Parameter SEED, default 32'h0000_0001, is the PRNG state loaded at reset; it is nonzero.
REQ-003 Derived constant NBITS = WIDTH*clog2(WIDTH) - WIDTH/2, which is 20 for WIDTH=8.
REQ-004 Derived constant WORDS = ceil(NBITS/32), which is 1 for WIDTH=8, 2 for 16 and 5 for 32.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 en  in  1  permits generation; GEN advances only while en=1.
REQ-008 seed_valid  in  1  loads seed_data into the PRNG this cycle.
REQ-009 seed_data  in  32  new PRNG seed.
REQ-010 ctrl_valid  out  1  ctrl_data holds a complete control word.
REQ-011 ctrl_ready  in  1  downstream switchn stage accepts ctrl_data.
REQ-012 ctrl_data  out  NBITS  Benes switch-control vector, registered.
REQ-013 busy  out  1  high while FSM is in GEN.

Function
REQ-014 PRNG step shall be next = (x<<13) ^ (x>>17) ^ (x<<5) on 32 bits, with shifted-out bits discarded; a zero result shall be replaced by 32'h1.
REQ-015 FSM shall have exactly three states: IDLE, GEN and HOLD.
REQ-016 IDLE shall go to GEN when en=1 and stay in IDLE otherwise.
REQ-017 In GEN with en=1, each cycle shall do three things: state<=next(state); next is written into accumulator word k (bits 32k+31:32k); k is incremented.
REQ-018 In GEN with en=0, state, accumulator and k shall hold unchanged.
REQ-019 When word WORDS-1 is written, ctrl_data<=accumulator[NBITS-1:0] (with that word included), ctrl_valid<=1, k<=0, and the FSM goes to HOLD.
REQ-020 Latency from GEN entry to ctrl_valid=1 shall be exactly WORDS en-high cycles.
REQ-021 Bits above NBITS in the last word shall be discarded.
REQ-022 Handshake: transfer occurs in a cycle with ctrl_valid & ctrl_ready.
REQ-023 ctrl_data and ctrl_valid shall be stable in HOLD until the transfer cycle.
REQ-024 On transfer, ctrl_valid<=0 and the FSM goes to GEN if en=1, else to IDLE.
REQ-025 No ctrl_valid pulse shall be dropped or duplicated.
REQ-026 ctrl_ready while ctrl_valid=0 shall be ignored.
REQ-027 seed_valid=1 in any state shall set state<=seed_data (zero mapped to 32'h1), clear the accumulator and k, set ctrl_valid<=0, and move the FSM to GEN if en=1, else to IDLE.
REQ-028 If seed_valid coincides with a HOLD transfer, the transfer shall complete and the next word shall derive from the new seed.
REQ-029 seed_valid shall take priority over a GEN step in the same cycle.
REQ-030 busy shall be a registered output equal to 1 exactly when the FSM is in GEN.

Reset
REQ-031 While rst=1, the block shall set state<=SEED, FSM<=IDLE, k<=0, accumulator<=0, ctrl_data<=0, ctrl_valid<=0 and busy<=0.
REQ-032 rst shall override seed_valid and any in-flight generation.
REQ-033 The first word after reset shall derive from SEED.

Structure
REQ-034 Shared package benes_pkg shall hold the nbits(width) function, the xorshift32 step function and the FSM state enum.
REQ-035 The PRNG step shall be a single sub-module instance, xorshift32, followed by the zero-substitute logic in the parent.
REQ-036 ctrl_data shall connect directly to the switchn control port of the same WIDTH.

Verification
REQ-037 WIDTH=8, reset, en=1, ctrl_ready=0: expect ctrl_valid=1 one cycle after GEN entry, with ctrl_data=20'h02020 held stable for 10 cycles.
REQ-038 WIDTH=16, reset, en=1: expect ctrl_valid after 2 GEN cycles, with ctrl_data=56'h000400_00002020.
REQ-039 WIDTH=8, ctrl_ready held 1: expect transfers every 2 cycles, successive words matching the step function starting 0x00002020, then 0x04000400, with no duplicates.
REQ-040 seed_valid with seed_data=0 mid-GEN (WIDTH=32, k=2): expect accumulator cleared, state=1, and the next ctrl_data word0=0x00002020 after 5 cycles.
REQ-041 en dropped for 3 cycles mid-GEN (WIDTH=32): expect busy=1, no state change, and latency extended by exactly 3 cycles.
REQ-042 rst asserted in HOLD: expect ctrl_valid=0, busy=0 and ctrl_data=0 next cycle, and the first post-reset word equal to that of REQ-037.
